// File: rtl/fetch_stage.sv
// Instruction fetch stage: loads the PC from a 4-entry vector table, then streams 16-bit instructions into IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds the fetchCount output (count of issued valid instructions).
module fetch_stage #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic [1:0]  fetchSrc,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch,
  input  logic [31:0] branchTarget,
  output logic [31:0] imemAddr,
  input  logic [15:0] imemData,
  output logic [15:0] instr,
  output logic [31:0] pcNext,
  output logic        valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount
`endif
);

  typedef enum logic [1:0] {IDLE, VEC_HI, VEC_LO, RUN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_sel;
  logic [15:0] r_instr_p1;
  logic [31:0] r_pcnext_p1;
  logic        r_vld_p1;

  logic [31:0] w_vec_hi_addr;
  logic [31:0] w_vec_lo_addr;
  logic [31:0] w_pc_inc;
  logic        w_advance;

  // Each vector is two halfwords: high half first, then low half.
  assign w_vec_hi_addr = VEC_BASE + {29'd0, r_sel, 1'b0};
  assign w_vec_lo_addr = VEC_BASE + {29'd0, r_sel, 1'b1};
  assign w_pc_inc      = r_pc + 32'd1;
  assign w_advance     = (r_state == RUN) && !fetch && !branch && !flush && !stall;

  always_comb begin
    imemAddr = 32'd0;
    case (r_state)
      VEC_HI:  imemAddr = w_vec_hi_addr;
      VEC_LO:  imemAddr = w_vec_lo_addr;
      RUN:     imemAddr = r_pc;
      default: imemAddr = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pc        <= 32'd0;
      r_sel       <= 2'd0;
      r_instr_p1  <= 16'd0;
      r_pcnext_p1 <= 32'd0;
      r_vld_p1    <= 1'b0;
    end else if (fetch) begin
      r_sel    <= fetchSrc;
      r_state  <= VEC_HI;
      r_vld_p1 <= 1'b0;
    end else begin
      case (r_state)
        VEC_HI: begin
          r_pc[31:16] <= imemData;
          r_state     <= VEC_LO;
        end
        VEC_LO: begin
          r_pc[15:0] <= imemData;
          r_state    <= RUN;
        end
        RUN: begin
          if (branch) begin
            r_pc     <= branchTarget;
            r_vld_p1 <= 1'b0;
          end else if (flush) begin
            r_vld_p1 <= 1'b0;
          end else if (!stall) begin
            // IF -> ID boundary
            r_instr_p1  <= imemData;
            r_pcnext_p1 <= w_pc_inc;
            r_vld_p1    <= 1'b1;
            r_pc        <= w_pc_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr  = r_instr_p1;
  assign pcNext = r_pcnext_p1;
  assign valid  = r_vld_p1;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_fetch_cnt <= 32'd0;
    else if (w_advance)
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign fetchCount = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector load, branch, stall, restart, wrap, priority, reset, optional counter.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch = 1'b0;
  logic [1:0]  fetchSrc = 2'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic [31:0] imemAddr;
  logic [15:0] imemData;
  logic [15:0] instr;
  logic [31:0] pcNext;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCount;
`endif

  logic [15:0] vec [0:7];
  int n_cmp = 0;
  int n_fail = 0;

  // Memory: vector table at halfwords 0..7, elsewhere data = addr[15:0] ^ 16'hA5A5.
  assign imemData = (imemAddr < 32'd8) ? vec[imemAddr[2:0]] : (imemAddr[15:0] ^ 16'hA5A5);

  always #5 clk = ~clk;

  fetch_stage #(.VEC_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .fetchSrc(fetchSrc), .stall(stall),
    .flush(flush), .branch(branch), .branchTarget(branchTarget),
    .imemAddr(imemAddr), .imemData(imemData), .instr(instr), .pcNext(pcNext),
    .valid(valid)
`ifdef FETCH_PERF_CNT_EN
    , .fetchCount(fetchCount)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL rst_addr got %h exp %h", imemAddr, 32'd0); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", valid); end
    n_cmp++; if (instr !== 16'd0) begin n_fail++; $display("FAIL rst_instr got %h exp 0000", instr); end
    n_cmp++; if (pcNext !== 32'd0) begin n_fail++; $display("FAIL rst_pcnext got %h exp 0", pcNext); end
    step; step;
    rst = 1'b1;
    step; step;
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL idle_addr got %h exp 0", imemAddr); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", valid); end
  endtask

  task automatic test_vector;
    vec[0] = 16'h0000; vec[1] = 16'h0020;
    fetch = 1'b1; fetchSrc = 2'd0;
    step;
    fetch = 1'b0;
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL vhi_addr got %h exp 0", imemAddr); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL vhi_valid got %b exp 0", valid); end
    step;
    n_cmp++; if (imemAddr !== 32'd1) begin n_fail++; $display("FAIL vlo_addr got %h exp 1", imemAddr); end
    step;
    n_cmp++; if (imemAddr !== 32'h20) begin n_fail++; $display("FAIL vrun_addr got %h exp 20", imemAddr); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL vrun_valid got %b exp 0", valid); end
    step;
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL vfirst_valid got %b exp 1", valid); end
    n_cmp++; if (pcNext !== 32'h21) begin n_fail++; $display("FAIL vfirst_pcnext got %h exp 21", pcNext); end
    n_cmp++; if (instr !== 16'hA585) begin n_fail++; $display("FAIL vfirst_instr got %h exp a585", instr); end
  endtask

  task automatic test_branch;
    vec[4] = 16'h0000; vec[5] = 16'h0040;
    fetch = 1'b1; fetchSrc = 2'd2;
    step;
    fetch = 1'b0;
    step; step;
    n_cmp++; if (imemAddr !== 32'h40) begin n_fail++; $display("FAIL br_pre_addr got %h exp 40", imemAddr); end
    branch = 1'b1; branchTarget = 32'h100;
    step;
    branch = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL br_valid got %b exp 0", valid); end
    n_cmp++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL br_addr got %h exp 100", imemAddr); end
    step;
    n_cmp++; if (instr !== 16'hA4A5) begin n_fail++; $display("FAIL br_instr got %h exp a4a5", instr); end
    n_cmp++; if (pcNext !== 32'h101) begin n_fail++; $display("FAIL br_pcnext got %h exp 101", pcNext); end
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL br_valid2 got %b exp 1", valid); end
  endtask

  task automatic test_stall;
    vec[6] = 16'h0000; vec[7] = 16'h004F;
    fetch = 1'b1; fetchSrc = 2'd3;
    step;
    fetch = 1'b0;
    step; step; step;
    n_cmp++; if (imemAddr !== 32'h50) begin n_fail++; $display("FAIL st_pre_addr got %h exp 50", imemAddr); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      n_cmp++; if (imemAddr !== 32'h50) begin n_fail++; $display("FAIL st_addr[%0d] got %h exp 50", i, imemAddr); end
      n_cmp++; if (instr !== 16'hA5EA) begin n_fail++; $display("FAIL st_instr[%0d] got %h exp a5ea", i, instr); end
      n_cmp++; if (pcNext !== 32'h50) begin n_fail++; $display("FAIL st_pcnext[%0d] got %h exp 50", i, pcNext); end
      n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL st_valid[%0d] got %b exp 1", i, valid); end
    end
    stall = 1'b0;
    step;
    n_cmp++; if (instr !== 16'hA5F5) begin n_fail++; $display("FAIL st_res_instr got %h exp a5f5", instr); end
    n_cmp++; if (pcNext !== 32'h51) begin n_fail++; $display("FAIL st_res_pcnext got %h exp 51", pcNext); end
  endtask

  task automatic test_restart;
    vec[2] = 16'h0001; vec[3] = 16'h2000;
    fetch = 1'b1; fetchSrc = 2'd3;
    step;
    fetch = 1'b0;
    n_cmp++; if (imemAddr !== 32'd6) begin n_fail++; $display("FAIL rs_hi3 got %h exp 6", imemAddr); end
    step;
    n_cmp++; if (imemAddr !== 32'd7) begin n_fail++; $display("FAIL rs_lo3 got %h exp 7", imemAddr); end
    fetch = 1'b1; fetchSrc = 2'd1;
    step;
    fetch = 1'b0;
    n_cmp++; if (imemAddr !== 32'd2) begin n_fail++; $display("FAIL rs_hi1 got %h exp 2", imemAddr); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid got %b exp 0", valid); end
    step;
    n_cmp++; if (imemAddr !== 32'd3) begin n_fail++; $display("FAIL rs_lo1 got %h exp 3", imemAddr); end
    step;
    n_cmp++; if (imemAddr !== 32'h0001_2000) begin n_fail++; $display("FAIL rs_pc got %h exp 00012000", imemAddr); end
  endtask

  task automatic test_wrap;
    vec[0] = 16'hFFFF; vec[1] = 16'hFFFF;
    fetch = 1'b1; fetchSrc = 2'd0;
    step;
    fetch = 1'b0;
    step; step;
    n_cmp++; if (imemAddr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wr_pre_addr got %h exp ffffffff", imemAddr); end
    step;
    n_cmp++; if (pcNext !== 32'd0) begin n_fail++; $display("FAIL wr_pcnext got %h exp 0", pcNext); end
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL wr_addr got %h exp 0", imemAddr); end
    n_cmp++; if (instr !== 16'h5A5A) begin n_fail++; $display("FAIL wr_instr got %h exp 5a5a", instr); end
    flush = 1'b1; stall = 1'b1;
    step;
    flush = 1'b0; stall = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fs_valid got %b exp 0", valid); end
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL fs_addr got %h exp 0", imemAddr); end
    n_cmp++; if (instr !== 16'h5A5A) begin n_fail++; $display("FAIL fs_instr got %h exp 5a5a", instr); end
  endtask

  task automatic test_priority;
    fetch = 1'b1; branch = 1'b1; fetchSrc = 2'd0; branchTarget = 32'h100;
    step;
    fetch = 1'b0;
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL pr_fetch_addr got %h exp 0", imemAddr); end
    stall = 1'b1;
    step;
    n_cmp++; if (imemAddr !== 32'd1) begin n_fail++; $display("FAIL pr_vec_ign got %h exp 1", imemAddr); end
    branch = 1'b0; stall = 1'b0;
    step;
    n_cmp++; if (imemAddr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL pr_run_addr got %h exp ffffffff", imemAddr); end
    branch = 1'b1; flush = 1'b1;
    step;
    branch = 1'b0; flush = 1'b0;
    n_cmp++; if (imemAddr !== 32'h100) begin n_fail++; $display("FAIL pr_bf_addr got %h exp 100", imemAddr); end
    step;
    n_cmp++; if (instr !== 16'hA4A5) begin n_fail++; $display("FAIL pr_bf_instr got %h exp a4a5", instr); end
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL pr_bf_valid got %b exp 1", valid); end
  endtask

  task automatic test_reset_mid;
    fetch = 1'b1; fetchSrc = 2'd1;
    step;
    fetch = 1'b0;
    step;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL rm_addr got %h exp 0", imemAddr); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", valid); end
    n_cmp++; if (instr !== 16'd0) begin n_fail++; $display("FAIL rm_instr got %h exp 0", instr); end
    n_cmp++; if (pcNext !== 32'd0) begin n_fail++; $display("FAIL rm_pcnext got %h exp 0", pcNext); end
    step;
    rst = 1'b1;
    step; step;
    n_cmp++; if (imemAddr !== 32'd0) begin n_fail++; $display("FAIL rm_idle_addr got %h exp 0", imemAddr); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rm_idle_valid got %b exp 0", valid); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf;
    n_cmp++; if (fetchCount !== 32'd0) begin n_fail++; $display("FAIL pc_rst got %0d exp 0", fetchCount); end
    vec[0] = 16'h0000; vec[1] = 16'h0020;
    fetch = 1'b1; fetchSrc = 2'd0;
    step;
    fetch = 1'b0;
    step; step;
    repeat (5) step;
    branch = 1'b1; branchTarget = 32'h100;
    step;
    branch = 1'b0; stall = 1'b1;
    step; step;
    stall = 1'b0;
    n_cmp++; if (fetchCount !== 32'd5) begin n_fail++; $display("FAIL pc_count got %0d exp 5", fetchCount); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) vec[i] = 16'h0000;
    test_reset;
    test_vector;
    test_branch;
    test_stall;
    test_restart;
    test_wrap;
    test_priority;
    test_reset_mid;
`ifdef FETCH_PERF_CNT_EN
    test_perf;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_0000, halfword base address of the 4-entry vector table.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port fetch, input, 1, vector-load request from fetch control.
REQ-005 SHALL have port fetchSrc, input, 2, vector select: 00 reset, 01 expt1, 10 expt2, 11 int.
REQ-006 SHALL have port stall, input, 1, hold PC and the IF/ID register.
REQ-007 SHALL have port flush, input, 1, kill the IF/ID register contents.
REQ-008 SHALL have port branch, input, 1, redirect PC to branchTarget.
REQ-009 SHALL have port branchTarget, input, 32, redirect halfword address.
REQ-010 SHALL have port imemAddr, output, 32, instruction memory halfword address; combinational read.
REQ-011 SHALL have port imemData, input, 16, memory read data, valid in the same cycle as imemAddr.
REQ-012 SHALL have port instr, output, 16, IF/ID instruction.
REQ-013 SHALL have port pcNext, output, 32, IF/ID PC+1 of instr.
REQ-014 SHALL have port valid, output, 1, IF/ID contents valid.

Function
REQ-015 SHALL implement FSM states IDLE, VEC_HI, VEC_LO, RUN with registered PC (32 b) and latched vector select (2 b).
REQ-016 Per-edge priority SHALL be: fetch > branch > flush > stall > normal advance.
REQ-017 fetch=1 at an edge in any state SHALL latch fetchSrc, enter VEC_HI and clear valid; a fetch during VEC_HI/VEC_LO restarts the sequence with the new select.
REQ-018 In VEC_HI, imemAddr SHALL be VEC_BASE+2*sel, and the edge SHALL load PC[31:16]<=imemData and enter VEC_LO.
REQ-019 In VEC_LO, imemAddr SHALL be VEC_BASE+2*sel+1, and the edge SHALL load PC[15:0]<=imemData and enter RUN.
REQ-020 stall, branch and flush SHALL be ignored in IDLE/VEC_HI/VEC_LO; valid SHALL stay 0 there.
REQ-021 In RUN, imemAddr SHALL equal PC.
REQ-022 In RUN, normal advance SHALL do: instr<=imemData, pcNext<=PC+1, valid<=1, PC<=PC+1.
REQ-023 In RUN, branch SHALL do: PC<=branchTarget, valid<=0, instr/pcNext held.
REQ-024 In RUN, flush without branch SHALL do: valid<=0, PC unchanged.
REQ-025 In RUN, stall SHALL hold PC, instr, pcNext and valid.
REQ-026 PC+1 SHALL wrap modulo 2^32 (32'hFFFF_FFFF -> 0).
REQ-027 Latency: a redirect (branch or vector) SHALL produce its first valid instruction 1 cycle (branch) or 3 cycles (vector) after the accepting edge.

Reset
REQ-028 While rst=0 the block SHALL set state=IDLE, PC=0, sel=0, instr=0, pcNext=0, valid=0, imemAddr=0, asynchronously.
REQ-029 In IDLE the block SHALL wait for fetch, with imemAddr=0 and no instruction issued.
REQ-030 Reset asserted mid-vector-sequence SHALL abandon the sequence; no partial PC shall survive.

Configuration
REQ-031 When macro FETCH_PERF_CNT_EN is defined, the block SHALL add output fetchCount (32 b) counting edges that set valid<=1, reset to 0 and wrapping modulo 2^32.
REQ-032 When FETCH_PERF_CNT_EN is undefined, fetchCount and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Release reset, fetch=1 with src=00 for one cycle, mem[0]=16'h0000, mem[1]=16'h0020 -> VEC_HI then VEC_LO, PC=32'h20, first valid=1 with pcNext=32'h21 three edges after fetch.
REQ-034 RUN at PC=32'h40, branch=1 with target 32'h100 -> valid=0 next cycle, imemAddr=32'h100, next edge instr=mem[0x100], pcNext=32'h101.
REQ-035 RUN at PC=32'h50, stall=1 for 3 cycles -> imemAddr, instr, pcNext, valid frozen; resumes at 32'h50 on release.
REQ-036 fetch with src=01 during VEC_LO of a src=11 sequence -> restart at VEC_BASE+2/+3, final PC from the expt1 vector.
REQ-037 PC=32'hFFFF_FFFF normal advance -> pcNext=0, PC=0; flush+stall together in RUN -> valid=0, PC held.
REQ-038 With FETCH_PERF_CNT_EN defined, 5 normal advances, 1 branch, 2 stalls -> fetchCount=5.
